// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg: shared types, defaults and helpers for the CNN layer sequencer.
//   sched_state_e  - sequencer FSM states (explicit 3-bit encoding)
//   sel_t          - result of the enabled-layer search (found flag + index)
//   next_enabled() - lowest enabled layer at or above a starting index
package cnn_sched_pkg;

  localparam int MAX_LAYERS    = 8;
  localparam int DRAIN_CYC_DEF = 3;
  localparam int WDOG_W_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } sel_t;

  // Scan from the top down so the last hit kept is the lowest enabled index >= idx.
  function automatic sel_t next_enabled(input logic [MAX_LAYERS-1:0] mask,
                                        input logic [2:0]            idx);
    sel_t r;
    r.found = 1'b0;
    r.idx   = idx;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= idx)) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_wdog.sv
// sched_wdog: per-layer watchdog, a loadable saturating up-counter.
//   clk, rstn   - clock, asynchronous active-low reset
//   clr_i       - synchronous clear to zero (highest priority)
//   load_i      - synchronous load of load_val_i
//   en_i        - count enable
//   lim_i       - limit; zero disables expiry
//   expired_o   - high in the counting cycle in which the count reaches lim_i
module sched_wdog
  import cnn_sched_pkg::*;
#(
  parameter int W = WDOG_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cntInc;

  // Saturating increment: once the counter is all-ones it stays there, so a
  // stuck layer can never wrap around and hide from the limit compare.
  always_comb begin
    cntInc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  // Expiry looks at the post-increment value so that a limit of N gives
  // exactly N enabled cycles before the timeout is reported.
  always_comb begin
    expired_o = en_i && (lim_i != '0) && (cntInc >= lim_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cntInc;
    end
  end

endmodule

// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched: top-level layer sequencer for the CNN accelerator.
// Runs the enabled layer controllers one after another, holding each one's
// level-sensitive valid until its done, draining between layers and toggling
// the ping-pong feature-buffer select.
//   clk, rstn      - clock, asynchronous active-low reset
//   start_i        - one-cycle start pulse (ignored while busy)
//   abort_i        - synchronous abort request (ignored when idle)
//   layer_en_i     - per-layer enable mask, disabled layers are skipped
//   wdog_lim_i     - per-layer watchdog limit in cycles, 0 disables
//   layer_done_i   - per-layer done, pulse or level
//   layer_valid_o  - one-hot (or zero) valid to the layer controllers
//   buf_sel_o      - active layer reads bank buf_sel_o, writes ~buf_sel_o
//   cur_layer_o    - index of the active (or last) layer
//   busy_o         - high from accepted start until completion
//   irq_o, err_o   - sticky completion interrupt / timeout-or-abort flag
//   irq_clr_i      - clears irq_o and err_o
module cnn_layer_sched
  import cnn_sched_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int DRAIN_CYC  = DRAIN_CYC_DEF,
  parameter int WDOG_W     = WDOG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_LAYERS-1:0] layer_en_i,
  input  logic [WDOG_W-1:0]     wdog_lim_i,
  input  logic [NUM_LAYERS-1:0] layer_done_i,
  output logic [NUM_LAYERS-1:0] layer_valid_o,
  output logic                  buf_sel_o,
  output logic [2:0]            cur_layer_o,
  output logic                  busy_o,
  output logic                  irq_o,
  input  logic                  irq_clr_i,
  output logic                  err_o
);

  // The SEL cycle also keeps valid low, so DRAIN itself only needs
  // DRAIN_CYC-1 cycles for valid to be low DRAIN_CYC cycles between layers.
  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  sched_state_e          state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_LAYERS-1:0] valid_q, valid_d;
  logic                  bufSel_q, bufSel_d;
  logic                  busy_q, busy_d;
  logic                  irq_q, irq_d;
  logic                  err_q, err_d;
  logic [DCW-1:0]        drainCnt_q, drainCnt_d;

  logic [MAX_LAYERS-1:0] en8;
  logic [MAX_LAYERS-1:0] done8;
  sel_t                  sel;
  logic                  wdClr, wdEn, wdExpired;
  logic                  drainLast;
  logic                  abortAct;

  // Widen the per-layer vectors to the package's fixed 8-lane view.
  always_comb begin
    en8                     = '0;
    en8[NUM_LAYERS-1:0]     = layer_en_i;
    done8                   = '0;
    done8[NUM_LAYERS-1:0]   = layer_done_i;
    sel                     = next_enabled(en8, idx_q);
  end

  sched_wdog #(.W(WDOG_W)) u_wdog (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (wdClr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (wdEn),
    .lim_i      (wdog_lim_i),
    .expired_o  (wdExpired)
  );

  // Next-state logic. The per-state case handles the normal flow; the
  // end-of-drain step and the abort override are applied afterwards so that
  // abort outranks a same-cycle done, timeout or drain completion. Abort is
  // not honoured in FIN because that cycle is already finishing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    bufSel_d   = bufSel_q;
    busy_d     = busy_q;
    irq_d      = irq_q;
    err_d      = err_q;
    drainCnt_d = drainCnt_q;
    wdClr      = 1'b0;
    wdEn       = 1'b0;
    drainLast  = 1'b0;
    abortAct   = abort_i && ((state_q == ST_SEL) || (state_q == ST_RUN) ||
                             (state_q == ST_DRAIN));

    if (irq_clr_i) begin
      irq_d = 1'b0;
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          busy_d   = 1'b1;
          bufSel_d = 1'b0;
          idx_d    = 3'd0;
          state_d  = (en8 != '0) ? ST_SEL : ST_FIN;
        end
      end
      ST_SEL: begin
        if (sel.found) begin
          idx_d   = sel.idx;
          valid_d = (NUM_LAYERS)'(1) << sel.idx;
          wdClr   = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_RUN: begin
        wdEn = 1'b1;
        if (done8[idx_q]) begin
          valid_d    = '0;
          drainCnt_d = '0;
          if (DRAIN_CYC == 1) begin
            drainLast = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (wdExpired) begin
          valid_d = '0;
          err_d   = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_DRAIN: begin
        if (drainCnt_q == DCW'(DRAIN_CYC - 2)) begin
          drainLast = 1'b1;
        end else begin
          drainCnt_d = drainCnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        irq_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abortAct) begin
      valid_d = '0;
      err_d   = 1'b1;
      state_d = ST_FIN;
    end else if (drainLast) begin
      if (idx_q == 3'(NUM_LAYERS - 1)) begin
        state_d = ST_FIN;
      end else begin
        bufSel_d = ~bufSel_q;
        idx_d    = idx_q + 3'd1;
        state_d  = ST_SEL;
      end
    end
  end

  // All sequencer state; reset drops valid immediately without a drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      valid_q    <= '0;
      bufSel_q   <= 1'b0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      bufSel_q   <= bufSel_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  assign layer_valid_o = valid_q;
  assign buf_sel_o     = bufSel_q;
  assign cur_layer_o   = idx_q;
  assign busy_o        = busy_q;
  assign irq_o         = irq_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// tb_cnn_layer_sched: self-checking bench for cnn_layer_sched.
// A recorder turns the cycle-by-cycle valid waveform into a list of served
// layers (index, valid-high length, buffer select, low gap before it) and
// compares it with a list computed directly from the enable mask, the
// per-layer done delays and the watchdog limit.
module tb_cnn_layer_sched;

  localparam int NL = 4;
  localparam int DC = 3;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          irq_clr_i = 1'b0;
  logic [NL-1:0] layer_en_i = '0;
  logic [NL-1:0] layer_done_i = '0;
  logic [WW-1:0] wdog_lim_i = '0;
  logic [NL-1:0] layer_valid_o;
  logic          buf_sel_o;
  logic [2:0]    cur_layer_o;
  logic          busy_o;
  logic          irq_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;

  // Stimulus knobs used by the recorder
  int            dly [NL];
  logic [NL-1:0] stuckMask = '0;
  logic [NL-1:0] neverMask = '0;
  int            glitchCycle = 0;

  // Recorded behaviour
  int   recLayer[$];
  int   recLen[$];
  int   recBuf[$];
  int   recGap[$];
  int   oneHotErrs;
  int   curErrs;
  logic timedOut;
  logic busyAtIrq;

  // Expected behaviour
  int   expLayer[$];
  int   expLen[$];
  logic expErr;

  always #5 clk = ~clk;

  cnn_layer_sched #(.NUM_LAYERS(NL), .DRAIN_CYC(DC), .WDOG_W(WW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .layer_en_i    (layer_en_i),
    .wdog_lim_i    (wdog_lim_i),
    .layer_done_i  (layer_done_i),
    .layer_valid_o (layer_valid_o),
    .buf_sel_o     (buf_sel_o),
    .cur_layer_o   (cur_layer_o),
    .busy_o        (busy_o),
    .irq_o         (irq_o),
    .irq_clr_i     (irq_clr_i),
    .err_o         (err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Layers are served in ascending order of the enable mask. A stuck-high done
  // finishes a layer in its first valid cycle; a layer whose done would come
  // later than the watchdog limit is cut off after exactly 'lim' valid cycles
  // and ends the whole sequence with an error.
  task automatic buildExpected(input logic [NL-1:0] en, input int lim);
    expLayer.delete();
    expLen.delete();
    expErr = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (en[l]) begin
        int d;
        d = stuckMask[l] ? 1 : (neverMask[l] ? 1000000 : dly[l]);
        expLayer.push_back(l);
        if (lim != 0 && d > lim) begin
          expLen.push_back(lim);
          expErr = 1'b1;
          break;
        end
        expLen.push_back(d);
      end
    end
  endtask

  // Pulse start and record the run until irq_o rises or the budget runs out.
  // Each layer's done is raised in the cycle its valid has been high dly[] cycles.
  task automatic applyStimulus(input int budget);
    int            high;
    int            low;
    int            cyc;
    int            curL;
    logic [NL-1:0] prevV;
    logic [NL-1:0] v;
    logic [NL-1:0] done;
    high = 0; low = 0; cyc = 0; curL = 0; prevV = '0;
    recLayer.delete(); recLen.delete(); recBuf.delete(); recGap.delete();
    oneHotErrs = 0; curErrs = 0; timedOut = 1'b0; busyAtIrq = 1'b1;
    @(negedge clk);
    start_i      = 1'b1;
    layer_done_i = stuckMask;
    forever begin
      @(negedge clk);
      start_i = (cyc == glitchCycle) && busy_o;
      cyc++;
      v = layer_valid_o;
      if (irq_o) begin
        busyAtIrq = busy_o;
        break;
      end
      if (cyc > budget) begin
        timedOut = 1'b1;
        break;
      end
      if (v != '0) begin
        if (!$onehot(v)) oneHotErrs++;
        if (prevV == '0) begin
          for (int l = 0; l < NL; l++) if (v[l]) curL = l;
          recLayer.push_back(curL);
          recBuf.push_back(int'(buf_sel_o));
          if (recLayer.size() > 1) recGap.push_back(low);
          high = 1;
        end else begin
          high++;
        end
        if (cur_layer_o != 3'(curL)) curErrs++;
      end else begin
        if (prevV != '0) begin
          recLen.push_back(high);
          low = 1;
        end else begin
          low++;
        end
      end
      prevV = v;
      done  = stuckMask;
      if (v != '0 && !neverMask[curL] && high == dly[curL]) done = done | v;
      layer_done_i = done;
    end
    if (prevV != '0) recLen.push_back(high);
    start_i      = 1'b0;
    layer_done_i = '0;
  endtask

  task automatic checkRun(input string name);
    checkOutput({name, "_served"}, recLayer.size(), expLayer.size());
    checkOutput({name, "_timeout"}, timedOut, 0);
    checkOutput({name, "_irq"}, irq_o, 1);
    checkOutput({name, "_err"}, err_o, expErr);
    checkOutput({name, "_busy_at_irq"}, busyAtIrq, 0);
    checkOutput({name, "_onehot"}, oneHotErrs, 0);
    checkOutput({name, "_cur_layer"}, curErrs, 0);
    for (int i = 0; i < expLayer.size() && i < recLayer.size(); i++) begin
      checkOutput($sformatf("%s_layer%0d", name, i), recLayer[i], expLayer[i]);
      checkOutput($sformatf("%s_len%0d", name, i), (i < recLen.size()) ? recLen[i] : -1, expLen[i]);
      checkOutput($sformatf("%s_buf%0d", name, i), recBuf[i], i % 2);
      if (i > 0)
        checkOutput($sformatf("%s_gap%0d", name, i), (i - 1 < recGap.size()) ? recGap[i-1] : -1, DC);
    end
  endtask

  task automatic clearIrq(input string name);
    @(negedge clk);
    irq_clr_i = 1'b1;
    @(negedge clk);
    irq_clr_i = 1'b0;
    checkOutput({name, "_irq_cleared"}, irq_o, 0);
    checkOutput({name, "_err_cleared"}, err_o, 0);
  endtask

  initial begin
    int            w;
    int            lim;
    logic [NL-1:0] seenV;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", layer_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_irq", irq_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_buf_sel", buf_sel_o, 0);
    checkOutput("rst_cur_layer", cur_layer_o, 0);
    rstn = 1'b1;

    // Normal run, all layers, done on the 5th valid cycle, stray start mid-run
    $display("[TB] normal run");
    layer_en_i = 4'b1111; wdog_lim_i = '0;
    for (int l = 0; l < NL; l++) dly[l] = 5;
    glitchCycle = 9;
    buildExpected(layer_en_i, 0);
    applyStimulus(500);
    checkRun("normal");
    clearIrq("normal");

    // Skipped layers
    $display("[TB] skip layers");
    layer_en_i = 4'b0101;
    buildExpected(layer_en_i, 0);
    applyStimulus(500);
    checkRun("skip");
    clearIrq("skip");

    // Nothing enabled
    layer_en_i = 4'b0000;
    buildExpected(layer_en_i, 0);
    applyStimulus(50);
    checkRun("none");
    clearIrq("none");

    // Watchdog cuts off layer 1
    $display("[TB] watchdog");
    layer_en_i = 4'b1111; wdog_lim_i = 16'd10; neverMask = 4'b0010;
    buildExpected(layer_en_i, 10);
    applyStimulus(500);
    checkRun("wdog");
    clearIrq("wdog");

    // Watchdog disabled: layer 1 stays valid, then abort ends the run
    wdog_lim_i = '0;
    applyStimulus(200);
    checkOutput("nowdog_still_running", timedOut, 1);
    checkOutput("nowdog_valid", layer_valid_o, 4'b0010);
    checkOutput("nowdog_err", err_o, 0);
    checkOutput("nowdog_irq", irq_o, 0);
    checkOutput("nowdog_busy", busy_o, 1);
    neverMask = '0;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("nowdog_abort_valid", layer_valid_o, 0);
    checkOutput("nowdog_abort_err", err_o, 1);
    @(negedge clk);
    checkOutput("nowdog_abort_irq", irq_o, 1);
    clearIrq("nowdog");

    // Abort together with layer 0 done, irq_clr in the FIN cycle
    $display("[TB] abort collision");
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    w = 0;
    while (layer_valid_o != 4'b0001 && w < 20) begin @(negedge clk); w++; end
    checkOutput("abort_l0_valid", layer_valid_o, 4'b0001);
    @(negedge clk);
    abort_i = 1'b1; layer_done_i = 4'b0001;
    @(negedge clk);
    abort_i = 1'b0; layer_done_i = '0;
    checkOutput("abort_valid_low", layer_valid_o, 0);
    checkOutput("abort_err", err_o, 1);
    checkOutput("abort_irq_pending", irq_o, 0);
    irq_clr_i = 1'b1;
    @(negedge clk);
    irq_clr_i = 1'b0;
    checkOutput("abort_irq_set_wins", irq_o, 1);
    checkOutput("abort_busy_low", busy_o, 0);
    seenV = '0;
    repeat (10) begin @(negedge clk); seenV = seenV | layer_valid_o; end
    checkOutput("abort_no_more_valid", seenV, 0);
    clearIrq("abort");

    // Stuck-high done on layers 2,3 is ignored until they are active
    $display("[TB] stuck done");
    for (int l = 0; l < NL; l++) dly[l] = 4;
    stuckMask = 4'b1100;
    buildExpected(layer_en_i, 0);
    applyStimulus(500);
    checkRun("stuck");
    stuckMask = '0;
    clearIrq("stuck");

    // Randomized runs
    $display("[TB] random runs");
    for (int it = 0; it < 12; it++) begin
      layer_en_i = 4'($urandom_range(1, 15));
      lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 12));
      for (int l = 0; l < NL; l++) begin
        dly[l] = $urandom_range(1, 12);
        while (dly[l] == lim) dly[l] = $urandom_range(1, 12);
      end
      wdog_lim_i  = WW'(lim);
      glitchCycle = $urandom_range(2, 20);
      buildExpected(layer_en_i, lim);
      applyStimulus(500);
      checkRun($sformatf("rand%0d", it));
      clearIrq($sformatf("rand%0d", it));
    end

    // Asynchronous reset mid-RUN with irq already pending
    $display("[TB] reset mid-run");
    wdog_lim_i = '0; layer_en_i = 4'b0000;
    buildExpected(layer_en_i, 0);
    applyStimulus(50);
    checkOutput("rstrun_irq_before", irq_o, 1);
    layer_en_i = 4'b1111;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    w = 0;
    while (layer_valid_o == '0 && w < 20) begin @(negedge clk); w++; end
    checkOutput("rstrun_valid_seen", layer_valid_o, 4'b0001);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rstrun_valid", layer_valid_o, 0);
    checkOutput("rstrun_busy", busy_o, 0);
    checkOutput("rstrun_irq", irq_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstrun_idle_valid", layer_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sched.md
Name: cnn_layer_sched

Overview:
- Top-level layer sequencer for the CNN accelerator.
- On a CPU start pulse, runs the conv/pool/FC layer controllers (L1ConvInCtrl, L2ConvInCtrl, ...) one after another.
- Drives each layer's level-sensitive valid input. Waits for the layer's done, then drops valid so the layer's standby state returns to idle.
- Toggles the ping-pong feature-buffer select between layers and raises a sticky interrupt on completion or watchdog timeout.

Parameters:
NUM_LAYERS, 4, number of sequenced layers (2..8)
DRAIN_CYC, 3, cycles valid stays low after a layer's done before the next layer starts (>=1)
WDOG_W, 16, width of the per-layer watchdog counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start pulse from CPU register block
abort_i  in  1  synchronous abort request
layer_en_i  in  NUM_LAYERS  per-layer enable mask; disabled layers are skipped
wdog_lim_i  in  WDOG_W  watchdog limit in cycles; 0 disables the watchdog
layer_done_i  in  NUM_LAYERS  per-layer done, pulse or level
layer_valid_o  out  NUM_LAYERS  one-hot (or zero) ConvValid to layer controllers
buf_sel_o  out  1  ping-pong select: layer reads bank buf_sel_o and writes bank ~buf_sel_o
cur_layer_o  out  3  index of active layer
busy_o  out  1  high from accepted start until DONE/ERR
irq_o  out  1  sticky completion/error interrupt
irq_clr_i  in  1  clears irq_o and err_o
err_o  out  1  sticky watchdog-timeout/abort flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn, as already decided.
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- FSM states: IDLE, SEL, RUN, DRAIN, FIN.
- IDLE:
  - start_i with layer_en_i != 0 -> SEL. Clear buf_sel_o, set busy_o, set layer index to 0.
  - start_i with layer_en_i == 0 -> FIN directly. No valid is ever asserted.
- SEL (one cycle): advance the index to the lowest enabled layer >= index.
  - Found -> RUN.
  - None left -> FIN.
- RUN:
  - layer_valid_o[index] = 1 continuously, all other bits 0. Valid is registered: it rises the cycle after SEL.
  - Watchdog counts up from 0.
  - layer_done_i[index] = 1 -> DRAIN. Valid drops the next cycle. Done bits of non-active layers are ignored.
  - Watchdog count reaches wdog_lim_i (when nonzero) -> set err_o, go to FIN.
- DRAIN:
  - Valid low; count DRAIN_CYC cycles.
  - On the final cycle: toggle buf_sel_o, increment index, go to SEL.
  - If the index was NUM_LAYERS-1, go to FIN instead, without a toggle.
- FIN (one cycle): clear busy_o, set irq_o, go to IDLE. The error path also sets irq_o.
- Abort: abort_i in any non-IDLE state -> valid low next cycle, set err_o, go to FIN. Abort outranks a same-cycle done or timeout.
- Ignored inputs:
  - start_i while busy_o is high is ignored.
  - abort_i in IDLE is ignored.
- irq_clr_i:
  - Clears irq_o and err_o.
  - When asserted in the same cycle as FIN sets irq_o, the set wins.
- Widths and timing:
  - Watchdog saturates; it never wraps.
  - The index is 3 bits and NUM_LAYERS <= 8.
  - cur_layer_o holds the last index when idle.
- layer_en_i and wdog_lim_i are sampled live. Changing layer_en_i mid-run affects only layers not yet selected.
- Reset mid-run: everything returns to reset values immediately and asynchronously; valid drops without a drain.

Decomposition:
- Package cnn_sched_pkg holds:
  - FSM state enum.
  - Default constants DRAIN_CYC_DEF and WDOG_W_DEF.
  - Function next_enabled(mask, idx), returning the index and a found bit.
- Sub-module sched_wdog: a loadable saturating counter with clear, limit compare and a zero-disable. Instanced once.

Test Plan:
- Normal run: layer_en=4'b1111, each done one cycle, 5 cycles after valid rises.
  - valid goes 0001, 0010, 0100, 1000, with exactly 3 low cycles between layers.
  - buf_sel toggles 0->1->0->1; irq_o=1, err_o=0, busy_o falls with irq.
- Skip layers: layer_en=4'b0101.
  - Only valid[0] then valid[2] are asserted; buf_sel toggles once.
  - layer_en=0 gives irq with no valid ever asserted.
- Watchdog: wdog_lim=10, layer 1 never asserts done.
  - valid[1] is high for exactly 10 cycles, then err_o=1 and irq_o=1.
  - wdog_lim=0 with the same stimulus runs forever with no error.
- Abort and collisions:
  - abort_i in the same cycle as layer_done_i[0] -> err_o=1, no DRAIN, valid[1] never asserted.
  - start_i while busy is ignored.
  - irq_clr_i in the same cycle as FIN leaves irq_o=1.
- Stuck-level done: layer_done_i held high across layers (L2ConvInCtrl-style standby).
  - Only the active layer's done bit advances the sequence.
  - Asynchronous rstn mid-RUN clears valid, busy and irq within the same cycle.
